// File: rtl/stream_demux.sv
// stream_demux: registered 1:N valid/ready demux with packet-granular routing and out-of-range drop.
// Optional 16-bit saturating drop counter port when STREAM_DEMUX_DROP_CNT_EN is defined.
module stream_demux #(
    parameter int N_OUT  = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    input  logic [SEL_W-1:0]          sel,
    output logic                      s_ready,
    output logic [N_OUT*DATA_W-1:0]   m_data,
    output logic [N_OUT-1:0]          m_valid,
    output logic [N_OUT-1:0]          m_last,
    input  logic [N_OUT-1:0]          m_ready,
`ifdef STREAM_DEMUX_DROP_CNT_EN
    output logic                      err,
    output logic [15:0]               drop_cnt
`else
    output logic                      err
`endif
);
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_dest, r_out_dest;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid, r_out_last, r_err;
    logic                w_acc, w_in_range, w_load, w_bad, w_drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // In DROP the input never waits on the output register, which still drains independently.
    always_comb begin
        w_in_range  = 32'(sel) < N_OUT;
        w_drain     = r_out_valid && m_ready[r_out_dest];
        s_ready     = (r_state == DROP) || !r_out_valid || m_ready[r_out_dest];
        w_acc       = s_valid && s_ready;
        w_load      = w_acc && (r_state == PASS || (r_state == IDLE && w_in_range));
        w_bad       = w_acc && r_state == IDLE && !w_in_range;
        w_state_nxt = r_state;
        if (w_acc)
            w_state_nxt = s_last ? IDLE : (r_state != IDLE) ? r_state : w_in_range ? PASS : DROP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dest      <= '0;
            r_out_dest  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_acc && r_state == IDLE)
                r_dest <= sel;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= s_data;
                r_out_last  <= s_last;
                r_out_dest  <= (r_state == IDLE) ? sel : r_dest;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign err = r_err;

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        assign m_valid[k]                  = r_out_valid && (32'(r_out_dest) == k);
        assign m_last[k]                   = m_valid[k] && r_out_last;
        assign m_data[k*DATA_W +: DATA_W]  = m_valid[k] ? r_out_data : '0;
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_bad && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: randomized and directed stimulus against a beat-level reference model.
// Uses N_OUT=6 so that sel values 6 and 7 exercise the out-of-range drop path.
module tb_stream_demux;
    localparam int N = 6;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic [2:0]     sel = '0;
    logic           s_ready;
    logic [N*W-1:0] m_data;
    logic [N-1:0]   m_valid, m_last;
    logic [N-1:0]   m_ready = '1;
    logic           err;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    int n_checks = 0;
    int n_err = 0;

    // Reference model: the single pending output beat plus the packet context.
    bit       pv, pl, in_pkt, dropping, e_err;
    int       pd, pkt_dest, e_cnt;
    bit [7:0] pdata;

    always #5 clk = ~clk;

    stream_demux #(.N_OUT(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .sel(sel), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready),
`ifdef STREAM_DEMUX_DROP_CNT_EN
        .err(err), .drop_cnt(drop_cnt)
`else
        .err(err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return dropping || !pv || m_ready[pd];
    endfunction

    task automatic model_reset();
        pv = 0; pl = 0; pd = 0; pdata = 0;
        in_pkt = 0; dropping = 0; pkt_dest = 0; e_err = 0; e_cnt = 0;
    endtask

    task automatic check_outputs();
        logic [N-1:0]   ev, el;
        logic [N*W-1:0] ed;
        ev = pv ? N'(1 << pd) : '0;
        el = (pv && pl) ? N'(1 << pd) : '0;
        ed = pv ? (N*W)'(pdata) << (pd * W) : '0;
        check("m_valid", 64'(m_valid), 64'(ev));
        check("m_last", 64'(m_last), 64'(el));
        check("m_data", 64'(m_data), 64'(ed));
        check("s_ready", 64'(s_ready), 64'(exp_ready()));
        check("err", 64'(err), 64'(e_err));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt), 64'(e_cnt));
`endif
    endtask

    task automatic model_update();
        bit acc, drain, load;
        acc = s_valid && exp_ready();
        drain = pv && m_ready[pd];
        load = 0;
        e_err = 0;
        if (acc) begin
            if (!in_pkt) begin
                in_pkt = !s_last;
                if (int'(sel) < N) begin
                    load = 1; pkt_dest = int'(sel); dropping = 0;
                end else begin
                    e_err = 1; dropping = !s_last;
                    if (e_cnt < 16'hFFFF) e_cnt++;
                end
            end else if (dropping) begin
                if (s_last) begin in_pkt = 0; dropping = 0; end
            end else begin
                load = 1;
                if (s_last) in_pkt = 0;
            end
        end
        if (load) begin
            pv = 1; pd = pkt_dest; pdata = s_data; pl = s_last;
        end else if (drain) begin
            pv = 0;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic [2:0] s, input logic [N-1:0] mr);
        @(negedge clk);
        s_valid = v; s_data = d; s_last = l; sel = s; m_ready = mr;
        #1;
        check_outputs();
        model_update();
    endtask

    // Asserted between edges to exercise the asynchronous path; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        s_valid = 0;
        rst = 1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        model_reset();
        do_reset();
        // reset mid-packet with lane 3 stalled
        step(1, 8'h33, 0, 3'd3, '0);
        step(1, 8'h34, 0, 3'd3, '0);
        step(0, 8'h00, 0, 3'd0, '0);
        do_reset();
        step(1, 8'h11, 1, 3'd1, '1);
        step(0, 8'h00, 0, 3'd0, '1);
        // back-to-back packets to lanes 2 and 5
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), i == 3, 3'd2, '1);
        for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), i == 3, 3'd5, '1);
        step(0, 8'h00, 0, 3'd0, '1);
        // sel changes mid-packet but routing stays on lane 2
        step(1, 8'hC0, 0, 3'd2, '1);
        step(1, 8'hC1, 0, 3'd6, '1);
        step(1, 8'hC2, 1, 3'd6, '1);
        step(0, 8'h00, 0, 3'd0, '1);
        // lane 4 backpressure for three cycles
        step(1, 8'h5C, 0, 3'd4, '1);
        for (int i = 0; i < 3; i++) step(1, 8'h5D, 1, 3'd4, 6'b101111);
        step(1, 8'h5D, 1, 3'd4, '1);
        step(0, 8'h00, 0, 3'd0, '1);
        // out-of-range packet then a lane-0 packet
        for (int i = 0; i < 3; i++) step(1, 8'hE0 + 8'(i), i == 2, 3'd7, '0);
        step(1, 8'h0F, 1, 3'd0, '1);
        step(0, 8'h00, 0, 3'd0, '1);
        step(0, 8'h00, 0, 3'd0, '1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] mr;
            mr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                 3'($urandom_range(0, 7)), mr);
            if (i % 1000 == 999) do_reset();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1:N stream demultiplexer with valid/ready handshake and packet-granular routing. A packet enters on one slave port. Its destination is latched from `sel` on the first beat and held until the `s_last` beat. Beats leave through a single output register on the selected master lane. Packets with an out-of-range destination are consumed and discarded. The block replaces the fixed combinational 1:8 bit demux wherever routed multi-bit data needs flow control.

## Interface
- `N_OUT`, default 8: number of output channels, range 2..256.
- `DATA_W`, default 8: data width per beat.
- `SEL_W`, default `$clog2(N_OUT)`, minimum 1: width of `sel`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  DATA_W  input beat.
- `s_valid`  in  1  input beat valid.
- `s_last`  in  1  last beat of the packet.
- `sel`  in  SEL_W  destination; sampled only on the first beat of a packet.
- `s_ready`  out  1  input may be accepted.
- `m_data`  out  N_OUT*DATA_W  lane k is bits [k*DATA_W +: DATA_W].
- `m_valid`  out  N_OUT  one-hot or zero.
- `m_last`  out  N_OUT  last flag per lane.
- `m_ready`  in  N_OUT  per-lane ready.
- `err`  out  1  one-cycle pulse when a packet with `sel >= N_OUT` is first accepted.

## Operation
- Input transfer: `s_valid && s_ready`. Output transfer on lane k: `m_valid[k] && m_ready[k]`.
- FSM states:
  - IDLE: waiting for a first beat.
  - PASS: routing packet beats to the latched destination `dest`.
  - DROP: discarding beats of an out-of-range packet.
- First beat accepted in IDLE:
  - Latch `dest = sel`.
  - If `sel < N_OUT`: the beat goes to the output register. Next state is PASS, or IDLE if `s_last=1`.
  - Otherwise: the beat is discarded and `err` pulses. Next state is DROP, or IDLE if `s_last=1`.
- PASS: every accepted beat goes to lane `dest`. `sel` is ignored. An accepted `s_last` beat returns the FSM to IDLE.
- DROP: `s_ready=1` unconditionally. Beats are discarded and `m_valid` is unaffected. An accepted `s_last` beat returns the FSM to IDLE.
- Output register holds `{out_valid, out_data, out_last, out_dest}`.
  - `m_valid[k] = out_valid && (out_dest == k)`.
  - Non-selected lanes drive `m_data` = 0 and `m_last` = 0.
- `s_ready` outside DROP is `!out_valid || m_ready[out_dest]`, giving full-throughput pipelining. A packet ending while the previous beat is still stalled is allowed.
- In IDLE, an in-range first beat may be accepted while the output register holds the previous packet's last beat, subject to the same `s_ready` rule.
- `m_ready` on non-selected lanes is ignored.

## Timing
- Reset values:
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0.
  - `err` = 0.
  - FSM = IDLE, `dest` = 0, `out_valid` = 0.
  - Drop counter = 0 when enabled.
- Reset is asynchronous; it aborts a packet mid-stream. The partial packet is lost, with no recovery beat.
- Latency: a beat accepted in cycle t appears on `m_*` in cycle t+1.
- Throughput: one beat per cycle while the selected `m_ready` stays high.
- Simultaneous output drain and input accept in one cycle: the register reloads and `out_valid` stays 1.
- `m_data`, `m_last` and `m_valid` are stable while stalled (`m_valid[k]=1`, `m_ready[k]=0`).
- `err` is asserted in the cycle after the offending first beat is accepted, for exactly one cycle.
- `s_ready` is combinational from `m_ready`. There is no combinational path from `s_valid` to `m_valid`.

## Configuration
- Macro `STREAM_DEMUX_DROP_CNT_EN`.
- Defined:
  - Adds output port `drop_cnt`, 16 bits: count of discarded packets.
  - Increments on each IDLE acceptance of an out-of-range first beat.
  - Saturates at 16'hFFFF.
  - Cleared only by `rst`.
- Undefined: the port and the counter are absent. `err` behaviour is identical in both builds.

## Test plan
- Reset mid-packet: reset while `m_valid[3]=1` in PASS → all outputs 0, FSM in IDLE. A new packet with `sel=1`, `s_data=8'h11` then appears only on lane 1 one cycle after acceptance.
- Back-to-back packets, 4 beats each, data 8'hA0..A3 to `sel=2` then 8'hB0..B3 to `sel=5`, all `m_ready` high → 8 consecutive output cycles, 1 beat/cycle. `m_last[2]` is set on A3 and `m_last[5]` on B3. All other lanes stay 0.
- Mid-packet `sel` change: `sel` switches from 2 to 6 on beat 2 of a packet → all beats still land on lane 2.
- Backpressure: `m_ready[4]=0` for 3 cycles with a beat 8'h5C pending on lane 4 → `s_ready=0` and `m_data` lane 4 holds 8'h5C. On release, the beat transfers and the next accepted beat follows with no gap.
- Out-of-range destination, `N_OUT=6`: packet with `sel=7`, 3 beats → `s_ready=1` throughout, no `m_valid`, one `err` pulse, `drop_cnt`=1 when enabled. A following packet with `sel=0` routes correctly.
